counter_period_monitor: RTL and testbench

Downstream consumer of the 4-bit binary counter outputs `a`, `b`, `c`, `d`. The block samples the counter state each clock and finds entries into a designated start code. It measures the cycle length of the counter's sequence, locks when two consecutive periods agree, and flags period changes and stalled counters. It sits beside the counter in the same clock domain and feeds status and debug logic.

---
 rtl/counter_period_monitor_if.sv | 26 ++
 rtl/counter_period_monitor.sv | 133 +++++++++++++
 tb/tb_counter_period_monitor.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_period_monitor_if.sv
// rtl/counter_period_monitor_if.sv - counter state in, period/lock status out
// master drives the counter bits; slave is the monitor.
interface counter_period_monitor_if #(
  parameter int PERIOD_W = 8
);
  logic                a;
  logic                b;
  logic                c;
  logic                d;
  logic                locked;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                mismatch;
  logic                stuck;
  logic [7:0]          wrap_count;

  modport master (
    output a, b, c, d,
    input  locked, period, period_valid, mismatch, stuck, wrap_count
  );

  modport slave (
    input  a, b, c, d,
    output locked, period, period_valid, mismatch, stuck, wrap_count
  );
endinterface

// File: rtl/counter_period_monitor.sv
// rtl/counter_period_monitor.sv - measures counter cycle length, locks on repeats
// Detects entries into START_CODE, locks when two periods agree, flags changes and stalls.
module counter_period_monitor #(
  parameter logic [3:0] START_CODE  = 4'b1100,
  parameter int         STUCK_LIMIT = 8,
  parameter int         PERIOD_W    = 8
) (
  input logic                     clk,
  input logic                     reset,
  counter_period_monitor_if.slave mon
);
  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED, S_STUCK} state_t;

  localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
  localparam logic [7:0]          STUCK_LIM = 8'(STUCK_LIMIT);

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_code_q;
  logic [3:0]          r_prev_q;
  logic                r_prev_valid;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_ref;
  logic [7:0]          r_same_cnt;
  logic [7:0]          r_wrap_count;
  logic                r_period_valid;
  logic                r_mismatch;

  logic w_hit;
  logic w_to_stuck;
  logic w_first;
  logic w_match;
  logic w_relearn;
  logic w_overrun;

  // Entry into the start code only; dwelling on it is not a new hit.
  assign w_hit = r_prev_valid && (r_code_q == START_CODE) && (r_prev_q != START_CODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_SEARCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_to_stuck = 1'b0;
    w_first    = 1'b0;
    w_match    = 1'b0;
    w_relearn  = 1'b0;
    w_overrun  = 1'b0;
    if (r_state != S_STUCK && r_same_cnt == STUCK_LIM) begin
      w_next     = S_STUCK;
      w_to_stuck = 1'b1;
    end else begin
      case (r_state)
        S_STUCK:   if (r_code_q != r_prev_q) w_next = S_SEARCH;
        S_SEARCH:  if (w_hit) w_next = S_MEASURE;
        S_MEASURE: begin
          if (w_hit) begin
            w_next  = S_LOCKED;
            w_first = 1'b1;
          end else if (r_cnt == CNT_MAX) begin
            w_next = S_SEARCH;
          end
        end
        S_LOCKED: begin
          if (w_hit && r_cnt == r_ref) begin
            w_match = 1'b1;
          end else if (w_hit) begin
            w_next    = S_MEASURE;
            w_relearn = 1'b1;
          end else if (r_cnt == r_ref) begin
            // cnt would pass ref next cycle: the period has overrun
            w_next    = S_SEARCH;
            w_overrun = 1'b1;
          end
        end
        default: w_next = S_SEARCH;
      endcase
    end
  end

  always_comb begin
    mon.locked = (r_state == S_LOCKED);
    mon.stuck  = (r_state == S_STUCK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_code_q       <= '0;
      r_prev_q       <= '0;
      r_prev_valid   <= 1'b0;
      r_cnt          <= '0;
      r_same_cnt     <= '0;
      r_period       <= '0;
      r_ref          <= '0;
      r_wrap_count   <= '0;
      r_period_valid <= 1'b0;
      r_mismatch     <= 1'b0;
    end else begin
      r_code_q     <= {mon.a, mon.b, mon.c, mon.d};
      r_prev_q     <= r_code_q;
      r_prev_valid <= 1'b1;

      if (r_prev_valid && r_code_q == r_prev_q) begin
        if (r_same_cnt != STUCK_LIM) r_same_cnt <= r_same_cnt + 8'd1;
      end else begin
        r_same_cnt <= '0;
      end

      if (w_to_stuck)             r_cnt <= '0;
      else if (w_hit)             r_cnt <= PERIOD_W'(1);
      else if (r_cnt != CNT_MAX)  r_cnt <= r_cnt + PERIOD_W'(1);

      r_period_valid <= w_first | w_match | w_relearn;
      r_mismatch     <= w_relearn | w_overrun;
      if (w_first | w_match | w_relearn) r_period <= r_cnt;
      if (w_first | w_relearn)           r_ref    <= r_cnt;

      if (w_first)                               r_wrap_count <= '0;
      else if (w_match && r_wrap_count != 8'hFF) r_wrap_count <= r_wrap_count + 8'd1;
    end
  end

  assign mon.period       = r_period;
  assign mon.period_valid = r_period_valid;
  assign mon.mismatch     = r_mismatch;
  assign mon.wrap_count   = r_wrap_count;
endmodule

// File: tb/tb_counter_period_monitor.sv
// tb/tb_counter_period_monitor.sv - directed and random stimulus against a history-based model
module tb_counter_period_monitor;
  localparam logic [3:0] START = 4'b1100;
  localparam int         LIMIT = 8;
  localparam int         MAXC  = 255;

  typedef enum int {M_SEARCH, M_MEASURE, M_LOCKED, M_STUCK} mode_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  counter_period_monitor_if #(.PERIOD_W(8)) bus ();

  counter_period_monitor #(
    .START_CODE (START),
    .STUCK_LIMIT(LIMIT),
    .PERIOD_W   (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mon  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: h holds the sampled code history since reset, h[0] being the cleared register.
  int    h[$];
  mode_t m_mode;
  int    m_cnt, m_ref, m_period, m_wrap;
  bit    m_pv, m_mm;

  int pv_count = 0;
  int mm_count = 0;
  int last_mm_period = 0;

  logic [3:0] loop6 [6] = '{4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0000, 4'b0001};
  logic [3:0] loop5 [5] = '{4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0000};
  logic [3:0] dwell6[6] = '{4'b1100, 4'b1100, 4'b1100, 4'b1111, 4'b0000, 4'b0001};
  logic [3:0] ovr   [9] = '{4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0000,
                            4'b0001, 4'b0010, 4'b0011, 4'b0100};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge(input bit rst, input logic [3:0] code);
    int e;
    int run;
    int nxt;
    bit hit;
    bit change;
    m_pv = 1'b0;
    m_mm = 1'b0;
    if (rst) begin
      h.delete();
      h.push_back(0);
      m_mode = M_SEARCH;
      m_cnt = 0; m_ref = 0; m_period = 0; m_wrap = 0;
      return;
    end
    e      = h.size() - 1;
    hit    = (e >= 1) && (h[e] == int'(START)) && (h[e-1] != int'(START));
    change = (e >= 1) && (h[e] != h[e-1]);
    run = 0;
    for (int f = e - 1; f >= 1; f--) begin
      if (h[f] != h[f-1] || run == LIMIT) break;
      run++;
    end
    nxt = hit ? 1 : ((m_cnt < MAXC) ? m_cnt + 1 : m_cnt);
    if (m_mode != M_STUCK && run == LIMIT) begin
      m_mode = M_STUCK;
      nxt = 0;
    end else begin
      case (m_mode)
        M_STUCK:  if (change) m_mode = M_SEARCH;
        M_SEARCH: if (hit) m_mode = M_MEASURE;
        M_MEASURE: begin
          if (hit) begin
            m_period = m_cnt; m_ref = m_cnt; m_pv = 1'b1; m_wrap = 0; m_mode = M_LOCKED;
          end else if (m_cnt == MAXC) begin
            m_mode = M_SEARCH;
          end
        end
        M_LOCKED: begin
          if (hit && m_cnt == m_ref) begin
            m_period = m_cnt; m_pv = 1'b1;
            if (m_wrap < 255) m_wrap++;
          end else if (hit) begin
            m_period = m_cnt; m_ref = m_cnt; m_pv = 1'b1; m_mm = 1'b1; m_mode = M_MEASURE;
          end else if (m_cnt == m_ref) begin
            m_mm = 1'b1; m_mode = M_SEARCH;
          end
        end
        default: m_mode = M_SEARCH;
      endcase
    end
    m_cnt = nxt;
    h.push_back(int'(code));
  endfunction

  task automatic cyc(input logic [3:0] code, input bit rst);
    {bus.a, bus.b, bus.c, bus.d} = code;
    reset = rst;
    @(posedge clk);
    model_edge(rst, code);
    #1;
    check("locked",       32'(bus.locked),       32'(m_mode == M_LOCKED));
    check("stuck",        32'(bus.stuck),        32'(m_mode == M_STUCK));
    check("period",       32'(bus.period),       32'(m_period));
    check("period_valid", 32'(bus.period_valid), 32'(m_pv));
    check("mismatch",     32'(bus.mismatch),     32'(m_mm));
    check("wrap_count",   32'(bus.wrap_count),   32'(m_wrap));
    if (bus.period_valid === 1'b1) pv_count++;
    if (bus.mismatch === 1'b1) begin
      mm_count++;
      last_mm_period = int'(bus.period);
    end
  endtask

  function automatic logic [3:0] rand_nonstart();
    logic [3:0] v;
    v = 4'($urandom_range(0, 15));
    if (v == START) v = 4'b0011;
    return v;
  endfunction

  initial begin
    int pv0;
    int mm0;
    logic [3:0] seg[16];
    int len;
    int reps;
    int kind;
    logic [3:0] hold;

    cyc(4'h0, 1'b1);
    cyc(4'h0, 1'b1);
    check("rst_locked",  32'(bus.locked),       0);
    check("rst_period",  32'(bus.period),       0);
    check("rst_pv",      32'(bus.period_valid), 0);
    check("rst_mm",      32'(bus.mismatch),     0);
    check("rst_stuck",   32'(bus.stuck),        0);
    check("rst_wrap",    32'(bus.wrap_count),   0);

    // Lock on a 6-code loop
    mm0 = mm_count;
    for (int i = 0; i < 26; i++) begin
      cyc(loop6[i % 6], 1'b0);
      if (i == 6) check("lock_pre_locked", 32'(bus.locked), 0);
      if (i == 7) begin
        check("lock_pv",     32'(bus.period_valid), 1);
        check("lock_period", 32'(bus.period),       6);
        check("lock_locked", 32'(bus.locked),       1);
      end
    end
    check("lock_wrap3",  32'(bus.wrap_count), 3);
    check("lock_no_mm",  32'(mm_count - mm0), 0);
    for (int i = 26; i < 30; i++) cyc(loop6[i % 6], 1'b0);

    // Shortened loop
    mm0 = mm_count;
    for (int i = 0; i < 12; i++) begin
      cyc(loop5[i % 5], 1'b0);
      if (i == 6) begin
        check("short_mm",     32'(bus.mismatch), 1);
        check("short_period", 32'(bus.period),   5);
        check("short_unlock", 32'(bus.locked),   0);
      end
    end
    check("short_relock",  32'(bus.locked),     1);
    check("short_wrap0",   32'(bus.wrap_count), 0);
    check("short_mm_once", 32'(mm_count - mm0), 1);
    check("short_mm_per",  32'(last_mm_period), 5);
    for (int i = 12; i < 15; i++) cyc(loop5[i % 5], 1'b0);

    // Back to 6, then overrun
    for (int i = 0; i < 18; i++) cyc(loop6[i % 6], 1'b0);
    check("ovr_pre_locked", 32'(bus.locked), 1);
    for (int k = 0; k < 9; k++) begin
      cyc(ovr[k], 1'b0);
      if (k == 6) check("ovr_not_yet", 32'(bus.mismatch), 0);
      if (k == 7) begin
        check("ovr_mm",     32'(bus.mismatch), 1);
        check("ovr_unlock", 32'(bus.locked),   0);
        check("ovr_period", 32'(bus.period),   6);
      end
    end

    // Stuck counter
    for (int i = 0; i < 18; i++) cyc(loop6[i % 6], 1'b0);
    check("stk_pre_locked", 32'(bus.locked), 1);
    for (int k = 0; k < 12; k++) begin
      cyc(4'b0101, 1'b0);
      if (k == 9)  check("stk_not_yet", 32'(bus.stuck), 0);
      if (k == 10) begin
        check("stk_set",    32'(bus.stuck),  1);
        check("stk_locked", 32'(bus.locked), 0);
      end
    end
    for (int i = 0; i < 18; i++) begin
      cyc(loop6[i % 6], 1'b0);
      if (i == 0) check("stk_hold",  32'(bus.stuck), 1);
      if (i == 1) check("stk_clear", 32'(bus.stuck), 0);
    end
    check("stk_relock", 32'(bus.locked), 1);

    // Dwell on the start code counts once per loop
    pv0 = pv_count;
    mm0 = mm_count;
    for (int i = 0; i < 24; i++) cyc(dwell6[i % 6], 1'b0);
    check("dwell_pv4",    32'(pv_count - pv0), 4);
    check("dwell_no_mm",  32'(mm_count - mm0), 0);
    check("dwell_locked", 32'(bus.locked),     1);

    // Reset mid-lock
    cyc(loop6[0], 1'b1);
    check("mrst_locked", 32'(bus.locked),       0);
    check("mrst_period", 32'(bus.period),       0);
    check("mrst_wrap",   32'(bus.wrap_count),   0);
    check("mrst_pv",     32'(bus.period_valid), 0);
    for (int i = 0; i < 8; i++) begin
      cyc(loop6[i % 6], 1'b0);
      if (i == 6) check("mrst_one_hit",  32'(bus.locked), 0);
      if (i == 7) check("mrst_two_hits", 32'(bus.locked), 1);
    end

    // Never returns to start: MEASURE times out to SEARCH
    cyc(4'h0, 1'b1);
    pv0 = pv_count;
    cyc(START, 1'b0);
    for (int i = 0; i < 300; i++) cyc((i % 2) ? 4'b0010 : 4'b0001, 1'b0);
    check("sat_no_pv",  32'(pv_count - pv0), 0);
    check("sat_locked", 32'(bus.locked),     0);
    for (int i = 0; i < 2; i++) cyc(loop6[i], 1'b0);
    check("sat_search", 32'(pv_count - pv0), 0);
    for (int i = 2; i < 8; i++) cyc(loop6[i % 6], 1'b0);
    check("sat_relock", 32'(bus.locked), 1);
    check("sat_period", 32'(bus.period), 6);

    // Random segments: loops, holds, noise and occasional reset
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        len  = $urandom_range(2, 9);
        reps = $urandom_range(1, 4);
        seg[0] = START;
        for (int i = 1; i < len; i++) seg[i] = rand_nonstart();
        for (int r = 0; r < reps; r++)
          for (int i = 0; i < len; i++) cyc(seg[i], 1'b0);
      end else if (kind < 8) begin
        hold = 4'($urandom_range(0, 15));
        len  = $urandom_range(2, 14);
        for (int i = 0; i < len; i++) cyc(hold, 1'b0);
      end else if (kind == 8) begin
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) cyc(4'($urandom_range(0, 15)), 1'b0);
      end else begin
        cyc(4'($urandom_range(0, 15)), 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
